// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants and the coordinate type for the 640x480@60 video path.
package vga_timing_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing source (master) and the sprite renderers / VGA pins.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic        pix_en;
    coord_t      DrawX;
    coord_t      DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        frame_end;
    logic [15:0] frame_count;

    modport master (
        input  pix_en,
        output DrawX, DrawY, blank, hs, vs, frame_end, frame_count
    );

    modport slave (
        output pix_en,
        input  DrawX, DrawY, blank, hs, vs, frame_end, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Enabled shift register that lines hs/vs up with the renderers' registered RGB.
module sync_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: column/line counters, blank and sync decode, frame pulse and counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VIS    = VGA_H_VIS,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_VIS    = VGA_V_VIS,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIPE_DLY = 1
) (
    input  logic vga_clk,
    input  logic reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit the 10-bit column counter");
    end
    if (V_TOT > 1024) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit the 10-bit line counter");
    end
    if (PIPE_DLY > 4 || PIPE_DLY < 0) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..4");
    end

    localparam coord_t H_LAST  = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS_C = coord_t'(H_VIS);
    localparam coord_t V_VIS_C = coord_t'(V_VIS);
    localparam coord_t HS_BEG  = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END  = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_BEG  = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END  = coord_t'(V_VIS + V_FP + V_SYNC);

    coord_t      x_q, x_d, y_q, y_d;
    logic [15:0] fc_q, fc_d;
    logic        blank_q, blank_d;
    logic        hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
    logic        frame_end_q, frame_end_d;
    logic [1:0]  sync_dly;

    // Decode from the next-count values so the registered flags describe the
    // same pixel that DrawX/DrawY present in the following cycle.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        if (vga.pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fc_d = fc_q + 16'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        blank_d     = (x_d < H_VIS_C) && (y_d < V_VIS_C);
        hs_raw_d    = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_raw_d    = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
        frame_end_d = vga.pix_en && (x_d == H_LAST) && (y_d == V_LAST);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            y_q         <= '0;
            fc_q        <= '0;
            blank_q     <= 1'b1;
            hs_raw_q    <= ~SYNC_POL;
            vs_raw_q    <= ~SYNC_POL;
            frame_end_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            fc_q        <= fc_d;
            blank_q     <= blank_d;
            hs_raw_q    <= hs_raw_d;
            vs_raw_q    <= vs_raw_d;
            frame_end_q <= frame_end_d;
        end
    end

    if (PIPE_DLY == 0) begin : g_no_dly
        assign sync_dly = {hs_raw_q, vs_raw_q};
    end else begin : g_dly
        sync_delay #(
            .DEPTH  (PIPE_DLY),
            .WIDTH  (2),
            .RST_VAL({2{~SYNC_POL}})
        ) u_sync_delay (
            .clk  (vga_clk),
            .rst_n(reset_n),
            .en_i (vga.pix_en),
            .d_i  ({hs_raw_q, vs_raw_q}),
            .q_o  (sync_dly)
        );
    end

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.blank       = blank_q;
    assign vga.hs          = sync_dly[1];
    assign vga.vs          = sync_dly[0];
    assign vga.frame_end   = frame_end_q;
    assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: scoreboard of per-cycle expected raster outputs plus line/frame checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        coord_t      x;
        coord_t      y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        fe;
        logic [15:0] fc;
        logic        hs0;
        logic        vs0;
    } obs_t;

    localparam obs_t RST_EXP = '{x: 10'd0, y: 10'd0, blank: 1'b1, hs: 1'b1, vs: 1'b1,
                                 fe: 1'b0, fc: 16'd0, hs0: 1'b1, vs0: 1'b1};

    logic vga_clk = 1'b0;
    logic reset_n;

    vga_timing_gen_if vif ();
    vga_timing_gen_if vif0 ();

    vga_timing_gen #(.PIPE_DLY(1)) dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .vga    (vif)
    );

    vga_timing_gen #(.PIPE_DLY(0)) dut0 (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .vga    (vif0)
    );

    always #5 vga_clk = ~vga_clk;

    obs_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    int          mx, my;
    logic [15:0] mfc;
    logic        rhs, rvs, dhs, dvs, mfe, mblank;

    int          hs_lo, hs0_lo, vs_lo, fe_cnt;
    int          hs_fall_x, hs0_fall_x, vs_fall_x, vs_fall_y, fe_x, fe_y;
    logic        prev_hs, prev_hs0, prev_vs;

    coord_t      jx, jy;
    logic [15:0] jfc;

    function automatic obs_t sample();
        obs_t o;
        o = '{x: vif.DrawX, y: vif.DrawY, blank: vif.blank, hs: vif.hs, vs: vif.vs,
              fe: vif.frame_end, fc: vif.frame_count, hs0: vif0.hs, vs0: vif0.vs};
        return o;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mfc = 16'd0;
        rhs = 1'b1; rvs = 1'b1; dhs = 1'b1; dvs = 1'b1; mfe = 1'b0; mblank = 1'b1;
        prev_hs = 1'b1; prev_hs0 = 1'b1; prev_vs = 1'b1;
    endtask

    // Behavioural reference for 640x480, active-low sync, one-stage sync delay.
    task automatic model_step(input logic pe);
        obs_t e;
        if (pe) begin
            dhs = rhs;
            dvs = rvs;
            if (mx == 799) begin
                mx = 0;
                if (my == 524) begin
                    my  = 0;
                    mfc = mfc + 16'd1;
                end else begin
                    my = my + 1;
                end
            end else begin
                mx = mx + 1;
            end
        end
        rhs    = (mx >= 656 && mx < 752) ? 1'b0 : 1'b1;
        rvs    = (my >= 490 && my < 492) ? 1'b0 : 1'b1;
        mblank = (mx < 640) && (my < 480);
        mfe    = pe && (mx == 799) && (my == 524);
        e = '{x: coord_t'(mx), y: coord_t'(my), blank: mblank, hs: dhs, vs: dvs,
              fe: mfe, fc: mfc, hs0: rhs, vs0: rvs};
        sb.push_back(e);
    endtask

    task automatic clear_stats();
        hs_lo = 0; hs0_lo = 0; vs_lo = 0; fe_cnt = 0;
        hs_fall_x = -1; hs0_fall_x = -1; vs_fall_x = -1; vs_fall_y = -1; fe_x = -1; fe_y = -1;
    endtask

    task automatic check_out();
        obs_t e, g;
        g = sample();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: got output with no expected entry queued");
        end else begin
            e = sb.pop_front();
            assert (g === e) else begin
                errors++;
                $error("FAIL cycle: got x=%0d y=%0d blank=%b hs=%b vs=%b fe=%b fc=%0d hs0=%b vs0=%b expected x=%0d y=%0d blank=%b hs=%b vs=%b fe=%b fc=%0d hs0=%b vs0=%b",
                       g.x, g.y, g.blank, g.hs, g.vs, g.fe, g.fc, g.hs0, g.vs0,
                       e.x, e.y, e.blank, e.hs, e.vs, e.fe, e.fc, e.hs0, e.vs0);
            end
        end
        if (g.hs === 1'b0) hs_lo++;
        if (g.hs0 === 1'b0) hs0_lo++;
        if (g.vs === 1'b0) vs_lo++;
        if (prev_hs === 1'b1 && g.hs === 1'b0) hs_fall_x = int'(g.x);
        if (prev_hs0 === 1'b1 && g.hs0 === 1'b0) hs0_fall_x = int'(g.x);
        if (prev_vs === 1'b1 && g.vs === 1'b0) begin
            vs_fall_x = int'(g.x);
            vs_fall_y = int'(g.y);
        end
        if (g.fe === 1'b1) begin
            fe_cnt++;
            fe_x = int'(g.x);
            fe_y = int'(g.y);
        end
        prev_hs = g.hs; prev_hs0 = g.hs0; prev_vs = g.vs;
    endtask

    task automatic cyc(input logic pe);
        vif.pix_en  = pe;
        vif0.pix_en = pe;
        model_step(pe);
        @(posedge vga_clk);
        #1;
        check_out();
    endtask

    // Jump the raster position (and optionally frame_count) in a pix_en=0 cycle.
    task automatic jump(input int x, input int y, input logic [15:0] fc, input bit set_fc);
        vif.pix_en  = 1'b0;
        vif0.pix_en = 1'b0;
        jx = coord_t'(x); jy = coord_t'(y); jfc = fc;
        force dut.x_q  = jx;
        force dut.y_q  = jy;
        force dut0.x_q = jx;
        force dut0.y_q = jy;
        if (set_fc) force dut.fc_q = jfc;
        mx = x; my = y;
        if (set_fc) mfc = fc;
        model_step(1'b0);
        @(posedge vga_clk);
        #1;
        release dut.x_q;
        release dut.y_q;
        release dut0.x_q;
        release dut0.y_q;
        if (set_fc) release dut.fc_q;
        check_out();
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        vif.pix_en  = 1'b0;
        vif0.pix_en = 1'b0;
        model_reset();
        clear_stats();
        repeat (3) @(posedge vga_clk);
        #1;
        checks++;
        assert (sample() === RST_EXP) else begin
            errors++;
            $error("FAIL reset_state: got %h expected %h", sample(), RST_EXP);
        end
        reset_n = 1'b1;

        // First visible line and the blanking edge at column 640.
        repeat (640) cyc(1'b1);
        chk("x_after_640", int'(vif.DrawX), 640);
        chk("blank_after_640", int'(vif.blank), 0);

        // Rest of line 0: hsync window and line wrap.
        repeat (160) cyc(1'b1);
        chk("x_wrap", int'(vif.DrawX), 0);
        chk("y_step", int'(vif.DrawY), 1);
        chk("hs_low_len", hs_lo, 96);
        chk("hs_fall_x", hs_fall_x, 657);
        chk("hs0_low_len", hs0_lo, 96);
        chk("hs0_fall_x", hs0_fall_x, 656);

        // Vertical sync window.
        jump(0, 489, 16'd0, 1'b0);
        clear_stats();
        repeat (3200) cyc(1'b1);
        chk("vs_low_len", vs_lo, 1600);
        chk("vs_fall_y", vs_fall_y, 490);
        chk("vs_fall_x", vs_fall_x, 1);

        // Frame end and frame counter 0->1->2.
        jump(0, 523, 16'd0, 1'b0);
        clear_stats();
        repeat (1600) cyc(1'b1);
        chk("fe_count_f1", fe_cnt, 1);
        chk("fe_x", fe_x, 799);
        chk("fe_y", fe_y, 524);
        chk("fc_1", int'(vif.frame_count), 1);
        chk("frame_wrap_y", int'(vif.DrawY), 0);
        jump(0, 523, 16'd0, 1'b0);
        clear_stats();
        repeat (1600) cyc(1'b1);
        chk("fe_count_f2", fe_cnt, 1);
        chk("fc_2", int'(vif.frame_count), 2);

        // Divide-by-2 pixel enable: frame_end stays one vga_clk wide.
        jump(0, 524, 16'd0, 1'b0);
        clear_stats();
        repeat (800) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        chk("div2_fe_width", fe_cnt, 1);
        chk("div2_x", int'(vif.DrawX), 0);
        chk("div2_fc", int'(vif.frame_count), 3);

        // Asynchronous reset mid-frame at (300,200).
        jump(0, 200, 16'd0, 1'b0);
        repeat (300) cyc(1'b1);
        chk("pre_rst_x", int'(vif.DrawX), 300);
        chk("pre_rst_y", int'(vif.DrawY), 200);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        assert (sample() === RST_EXP) else begin
            errors++;
            $error("FAIL async_reset: got %h expected %h", sample(), RST_EXP);
        end
        model_reset();
        sb.delete();
        #1;
        reset_n = 1'b1;
        clear_stats();
        repeat (10) cyc(1'b1);
        chk("post_rst_x", int'(vif.DrawX), 10);
        chk("post_rst_y", int'(vif.DrawY), 0);

        // frame_count wrap 0xFFFF -> 0.
        jump(0, 524, 16'hFFFF, 1'b1);
        chk("fc_preload", int'(vif.frame_count), 16'hFFFF);
        repeat (800) cyc(1'b1);
        chk("fc_wrap", int'(vif.frame_count), 0);
        chk("fc_wrap_y", int'(vif.DrawY), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
